prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_word_packer.sv | 52 +++++
 rtl/prog_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, stream field
// widths, default load address and the word-count range check.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned COUNT_W    = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_BUS_W = 32;

  localparam logic [ADDR_BUS_W-1:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

  // True when a word count cannot fit in a memory of 2**addr_w words.
  function automatic logic count_exceeds(input logic [COUNT_W-1:0] n,
                                         input int unsigned addr_w);
    logic [COUNT_W:0] limit;
    limit = {{COUNT_W{1'b0}}, 1'b1} << addr_w;
    return ({1'b0, n} > limit);
  endfunction

endpackage

// File: rtl/prog_loader_word_packer.sv
// Little-endian byte-to-word assembler. Byte 0 lands in bits [7:0]; the
// completed word is presented with a one-cycle word_valid_o the cycle after
// its fourth byte is accepted. clear_i drops any partially assembled word.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              valid_i,
  input  logic              clear_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;

  // Next-state: place incoming byte at its lane and flag word completion.
  always_comb begin
    idx_d        = idx_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear_i) begin
      idx_d = 2'd0;
    end else if (valid_i) begin
      word_d[{idx_q, 3'b000} +: BYTE_W] = byte_i;
      idx_d        = idx_q + 2'd1;
      word_valid_d = (idx_q == 2'd3);
    end else begin
      idx_d = idx_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= 2'd0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses a count/data/checksum byte stream, writes the words
// into instruction memory and releases cpu_reset only on a verified load.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned              ADDR_W    = 8,
  parameter logic [ADDR_BUS_W-1:0]    BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BYTE_W-1:0]     in_data,
  input  logic                  reload,
  output logic                  wr_en,
  output logic [ADDR_BUS_W-1:0] wr_addr,
  output logic [WORD_W-1:0]     wr_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  state_e                state_q, state_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [COUNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0]     csum_q, csum_d;
  logic [ADDR_BUS_W-1:0] wr_addr_q, wr_addr_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  xfer_s;

  assign in_ready = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign xfer_s   = in_valid && in_ready;

  word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .byte_i       (in_data),
    .valid_i      (xfer_s && (state_q == ST_DATA)),
    .clear_i      (state_q == ST_HDR),
    .word_o       (wr_data),
    .word_valid_o (wr_en)
  );

  // Next-state: stream parsing, counters, checksum and status outputs.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    wr_addr_d  = wr_addr_q;
    case (state_q)
      ST_HDR: begin
        word_cnt_d = '0;
        byte_cnt_d = 2'd0;
        csum_d     = '0;
        if (xfer_s) begin
          count_d = in_data;
          if (count_exceeds(in_data, ADDR_W)) begin
            state_d = ST_ERR;
          end else if (in_data == 8'h00) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          csum_d     = csum_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Address is latched alongside the packer's completion pulse.
            wr_addr_d  = BASE_ADDR + {{(ADDR_BUS_W-COUNT_W-2){1'b0}}, word_cnt_q, 2'b00};
            word_cnt_d = word_cnt_q + 8'd1;
            if (word_cnt_q == (count_q - 8'd1)) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (xfer_s) begin
          state_d = (in_data == csum_q) ? ST_RUN : ST_ERR;
        end else begin
          state_d = ST_CSUM;
        end
      end
      ST_RUN, ST_ERR: begin
        if (reload) begin
          state_d = ST_HDR;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase
    cpu_reset_d = (state_d != ST_RUN);
    done_d      = (state_d == ST_RUN);
    error_d     = (state_d == ST_ERR);
  end

  // State and output registers; reset overrides reload and byte transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HDR;
      count_q     <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= 2'd0;
      csum_q      <= '0;
      wr_addr_q   <= BASE_ADDR;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      csum_q      <= csum_d;
      wr_addr_q   <= wr_addr_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign wr_addr   = wr_addr_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
